gray_counter_n: RTL and testbench
=================================

# gray_counter_n

Parametrised Gray-code counter with configurable width, up/down counting, synchronous parallel load, wrap or saturate mode, and sticky overflow/underflow flags. It extends the fixed 3-bit up-only Gray counter with one-shot overflow. Intended use: sequence generators and position counters in the datapath lab blocks, where only one output bit may change per step.

## Interface
- `WIDTH`, default 3: counter width in bits; legal range ≥ 2.
- `SATURATE`, default 0: 0 = wrap at terminal count; 1 = hold at terminal count.
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high reset.
- `En` in 1: count enable.
- `Dir` in 1: count direction; 0 = up, 1 = down.
- `Load` in 1: synchronous load strobe.
- `LoadValue` in WIDTH: load value, in binary encoding.
- `ClrFlag` in 1: synchronous clear of the sticky flags.
- `Output` out WIDTH: current count, Gray-encoded, registered.
- `Binary` out WIDTH: current count, binary-encoded, registered.
- `Overflow` out 1: sticky flag; an up-count was attempted at binary all-ones.
- `Underflow` out 1: sticky flag; a down-count was attempted at binary zero.
- `Wrap` out 1: one-cycle pulse; the counter wrapped on the previous edge.

## Operation
- State is a binary register `bin`.
  - `Binary` = `bin`.
  - `Output` = `bin ^ (bin >> 1)`; the Gray value is held in its own register, updated in the same edge as `bin`, so `Output` is glitch-free.
- Per-edge priority: Reset (async) > Load > En. With none of them active, all state holds.
- Load: `bin` ← `LoadValue`. `Wrap` is 0. Flags are unaffected except by `ClrFlag`. Load overrides `En` in the same cycle.
- Count (`En`=1, `Load`=0):
  - Up: `bin` ← `bin`+1.
  - Down: `bin` ← `bin`−1.
  - All arithmetic is modulo 2^WIDTH.
- Terminal events:
  - Up at all-ones sets `Overflow`.
  - Down at zero sets `Underflow`.
- Terminal behaviour with `SATURATE`=0:
  - `bin` wraps: all-ones → 0, or 0 → all-ones.
  - `Wrap`=1 for the next cycle only.
- Terminal behaviour with `SATURATE`=1:
  - `bin` holds its value.
  - `Wrap` never asserts.
  - Each event still sets the corresponding sticky flag.
- Flags:
  - Set on their event; stay set until Reset or `ClrFlag`.
  - If `ClrFlag` and a new event of the same flag occur in the same cycle, set wins.
  - `ClrFlag` has no effect on `bin` or `Wrap`.
- `Dir` is sampled only when `En`=1; toggling it while idle has no effect.
- Gray property: every count step changes exactly one `Output` bit, including the wrap step. Load may change several bits.

## Timing
- Reset asserted: immediately, `bin`=0, `Output`=0, `Binary`=0, `Overflow`=0, `Underflow`=0, `Wrap`=0. State is held while Reset stays high.
- Reset deasserted: counting begins on the first rising edge after deassertion with `En`=1.
- Reset mid-count overrides any pending load, count or flag event.
- Latency: all outputs update one edge after the controlling inputs are sampled. There are no combinational paths from inputs to outputs.
- `Wrap` is high for exactly one cycle per wrap event.
- Back-to-back wraps with alternating `Dir` produce a pulse on each edge.

## Structure
- Shared package `gray_pkg`:
  - `DIR_UP`=1'b0, `DIR_DOWN`=1'b1.
  - `MODE_WRAP`=0, `MODE_SAT`=1.
  - Function `bin2gray`.
- Sub-module `gray_conv` (parameter `WIDTH`): purely combinational `bin2gray` and `gray2bin`. It is instantiated for the `Output` register input, and for the bench checker.
- The remaining logic (next-state mux, terminal detect, flag registers, `Wrap` register) lives in a single always block with async reset.

## Test plan
1. WIDTH=3, `SATURATE`=0, `En`=1, `Dir`=0 for 9 edges → `Output` sequence 000,001,011,010,110,111,101,100,000.
   - `Overflow`=1 from the 8th edge onward.
   - `Wrap`=1 only after the 8th edge.
2. WIDTH=3, reset, then `Dir`=1 for 1 edge → `Binary`=7, `Output`=100, `Underflow`=1, `Wrap` pulses once, `Overflow`=0.
3. WIDTH=4, `SATURATE`=1: load 14, then 3 up-counts → `Binary` 15,15,15, `Output`=1000, `Overflow`=1, `Wrap` never 1.
4. Load=1 and `En`=1 in the same cycle with `LoadValue`=5 (WIDTH=3) → `Binary`=5, `Output`=111, no count applied. Next edge with `En`=1 gives `Binary`=6, `Output`=101.
5. `Overflow` set, then `ClrFlag`=1 in the same cycle as another wrap → `Overflow` stays 1. `ClrFlag`=1 alone → `Overflow`=0 next edge.
6. Reset asserted asynchronously mid-cycle with `Binary`=6 and flags set → all outputs 0 before the next edge. Randomised WIDTH=5 run: every count step changes exactly one `Output` bit.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared constants and the binary-to-Gray helper for the Gray counter family.
package gray_pkg;

  // Count direction as seen on the Dir input.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Terminal-count behaviour selected by the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Reflected binary code: each Gray bit is the XOR of adjacent binary bits.
  // Operates on up to 32 bits; callers truncate to their own width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Purely combinational binary<->Gray converters of a given width.
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray,
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_gray = WIDTH'(bin2gray(32'(i_bin)));

  // Binary bit k is the parity of all Gray bits at or above k.
  for (genvar k = 0; k < WIDTH; k++) begin : g_gray2bin
    assign o_bin[k] = ^i_gray[WIDTH-1:k];
  end

endmodule

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray counter with parallel load, wrap or saturate
// terminal behaviour, sticky overflow/underflow flags and a wrap pulse.
// The binary count and its Gray image are both registered on the same edge,
// so Output never glitches and no input reaches an output combinationally.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             ClrFlag,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_ov;
  logic             r_un;
  logic             r_wrap;

  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_gray_next;
  logic [WIDTH-1:0] w_bin_rt;
  logic             w_sat;
  logic             w_up;
  logic             w_count;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_ov_ev;
  logic             w_un_ev;
  logic             w_wrap_ev;

  assign w_sat     = (SATURATE == MODE_SAT);
  assign w_up      = (Dir == DIR_UP);
  assign w_count   = En & ~Load;
  assign w_at_max  = &r_bin;
  assign w_at_zero = ~|r_bin;

  // Terminal events: a count attempted past either end of the range.
  assign w_ov_ev   = w_count &  w_up & w_at_max;
  assign w_un_ev   = w_count & ~w_up & w_at_zero;
  assign w_wrap_ev = (w_ov_ev | w_un_ev) & ~w_sat;

  // Next binary value: load beats count; saturate mode freezes at the ends.
  always_comb begin
    w_bin_next = r_bin;
    if (Load) begin
      w_bin_next = LoadValue;
    end else if (En) begin
      if (w_up) begin
        if (!(w_at_max && w_sat)) w_bin_next = r_bin + WIDTH'(1);
      end else begin
        if (!(w_at_zero && w_sat)) w_bin_next = r_bin - WIDTH'(1);
      end
    end
  end

  // Gray image of the next count feeds its own register; the reverse
  // converter decodes the registered Gray value for the consistency check.
  gray_conv #(.WIDTH(WIDTH)) u_conv (
    .i_bin  (w_bin_next),
    .o_gray (w_gray_next),
    .i_gray (r_gray),
    .o_bin  (w_bin_rt)
  );

  // Count/Gray registers, wrap pulse and sticky flags (a new event beats ClrFlag).
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_ov   <= 1'b0;
      r_un   <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_ev;
      if (w_ov_ev)      r_ov <= 1'b1;
      else if (ClrFlag) r_ov <= 1'b0;
      if (w_un_ev)      r_un <= 1'b1;
      else if (ClrFlag) r_un <= 1'b0;
    end
  end

  // The two count registers must always describe the same value.
  a_gray_matches_bin: assert property (@(posedge Clk) disable iff (Reset) w_bin_rt == r_bin);

  assign Binary    = r_bin;
  assign Output    = r_gray;
  assign Overflow  = r_ov;
  assign Underflow = r_un;
  assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// Bench for gray_counter_n: three instances (3-bit wrap, 4-bit saturate,
// 5-bit wrap) share one stimulus stream; a reference model predicts each
// edge's outputs into a queue that a separate monitor drains and compares.
module tb_gray_counter_n;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       En = 1'b0;
  logic       Dir = 1'b0;
  logic       Load = 1'b0;
  logic       ClrFlag = 1'b0;
  logic [7:0] LoadValue = 8'd0;

  always #5 Clk = ~Clk;

  // ---------------- DUT outputs ----------------
  logic [2:0] b3, g3;
  logic [3:0] b4, g4;
  logic [4:0] b5, g5;
  logic       ov3, un3, wr3, ov4, un4, wr4, ov5, un5, wr5;
  logic [4:0] chk_g5, chk_b5;

  gray_counter_n #(.WIDTH(3), .SATURATE(0)) u_w3 (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadValue(LoadValue[2:0]), .ClrFlag(ClrFlag), .Output(g3), .Binary(b3),
    .Overflow(ov3), .Underflow(un3), .Wrap(wr3)
  );

  gray_counter_n #(.WIDTH(4), .SATURATE(1)) u_w4 (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadValue(LoadValue[3:0]), .ClrFlag(ClrFlag), .Output(g4), .Binary(b4),
    .Overflow(ov4), .Underflow(un4), .Wrap(wr4)
  );

  gray_counter_n #(.WIDTH(5), .SATURATE(0)) u_w5 (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadValue(LoadValue[4:0]), .ClrFlag(ClrFlag), .Output(g5), .Binary(b5),
    .Overflow(ov5), .Underflow(un5), .Wrap(wr5)
  );

  // Independent decode of the 5-bit instance's outputs.
  gray_conv #(.WIDTH(5)) u_chk (
    .i_bin(b5), .o_gray(chk_g5), .i_gray(g5), .o_bin(chk_b5)
  );

  logic [7:0] a_bin[3];
  logic [7:0] a_gray[3];
  logic       a_ov[3];
  logic       a_un[3];
  logic       a_wrap[3];

  assign a_bin[0]  = {5'd0, b3};
  assign a_bin[1]  = {4'd0, b4};
  assign a_bin[2]  = {3'd0, b5};
  assign a_gray[0] = {5'd0, g3};
  assign a_gray[1] = {4'd0, g4};
  assign a_gray[2] = {3'd0, g5};
  assign a_ov[0]   = ov3;
  assign a_ov[1]   = ov4;
  assign a_ov[2]   = ov5;
  assign a_un[0]   = un3;
  assign a_un[1]   = un4;
  assign a_un[2]   = un5;
  assign a_wrap[0] = wr3;
  assign a_wrap[1] = wr4;
  assign a_wrap[2] = wr5;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] gray;
    logic [7:0] prev_gray;
    logic       ov;
    logic       un;
    logic       wrap;
    logic       step;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  exp3_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model state (plain integers; instance i has width 3+i,
  // instance 1 saturates, the others wrap).
  int    m_bin[3];
  logic  m_ov[3];
  logic  m_un[3];

  function automatic logic [7:0] gray_of(input int v);
    return 8'(v ^ (v >> 1));
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic dir, input logic ld,
                      input logic [7:0] lv, input logic clr);
    exp3_t e;
    int    maxv;
    int    nb;
    logic  ov_ev, un_ev, wr;
    @(negedge Clk);
    En = en; Dir = dir; Load = ld; LoadValue = lv; ClrFlag = clr;
    for (int i = 0; i < 3; i++) begin
      maxv  = (1 << (3 + i)) - 1;
      nb    = m_bin[i];
      ov_ev = 1'b0; un_ev = 1'b0; wr = 1'b0;
      e[i].prev_gray = gray_of(m_bin[i]);
      if (ld) begin
        nb = int'(lv) & maxv;
      end else if (en && !dir) begin
        if (m_bin[i] == maxv) begin
          ov_ev = 1'b1;
          if (i != 1) begin nb = 0; wr = 1'b1; end
        end else nb = m_bin[i] + 1;
      end else if (en && dir) begin
        if (m_bin[i] == 0) begin
          un_ev = 1'b1;
          if (i != 1) begin nb = maxv; wr = 1'b1; end
        end else nb = m_bin[i] - 1;
      end
      m_ov[i]   = ov_ev | (m_ov[i] & ~clr);
      m_un[i]   = un_ev | (m_un[i] & ~clr);
      e[i].step = !ld && en && (nb != m_bin[i]);
      m_bin[i]  = nb;
      e[i].bin  = 8'(nb);
      e[i].gray = gray_of(nb);
      e[i].ov   = m_ov[i];
      e[i].un   = m_un[i];
      e[i].wrap = wr;
    end
    exp_q.push_back(e);
    @(posedge Clk);
    #2;
    En = 1'b0; Load = 1'b0; ClrFlag = 1'b0;
    Dir = 1'($urandom_range(0, 1));  // idle Dir changes must be ignored
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once and
  // stay cleared across an edge even with load/count requested.
  task automatic do_reset();
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_bin", i, a_bin[i], 8'd0);
      check("rst_gray", i, a_gray[i], 8'd0);
      check("rst_ov", i, {7'd0, a_ov[i]}, 8'd0);
      check("rst_un", i, {7'd0, a_un[i]}, 8'd0);
      check("rst_wrap", i, {7'd0, a_wrap[i]}, 8'd0);
      m_bin[i] = 0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
    end
    En = 1'b1; Load = 1'b1; LoadValue = 8'd5;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) check("rst_hold", i, a_bin[i], 8'd0);
    @(negedge Clk);
    En = 1'b0; Load = 1'b0;
    Reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  exp3_t me;

  // Pops one prediction per edge that had stimulus and compares all outputs.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() != 0) begin
      me = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        check("bin", i, a_bin[i], me[i].bin);
        check("gray", i, a_gray[i], me[i].gray);
        check("ov", i, {7'd0, a_ov[i]}, {7'd0, me[i].ov});
        check("un", i, {7'd0, a_un[i]}, {7'd0, me[i].un});
        check("wrap", i, {7'd0, a_wrap[i]}, {7'd0, me[i].wrap});
        if (me[i].step)
          check("one_bit", i, 8'($countones(a_gray[i] ^ me[i].prev_gray)), 8'd1);
      end
      check("conv_bin", 2, {3'd0, chk_b5}, me[2].bin);
      check("conv_gray", 2, {3'd0, chk_g5}, me[2].gray);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    int r;
    for (int i = 0; i < 3; i++) begin
      m_bin[i] = 0; m_ov[i] = 1'b0; m_un[i] = 1'b0;
    end
    do_reset();

    // Up-count through a full 3-bit cycle including the wrap.
    repeat (9) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Single down-count from zero.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Load near the top and push into the terminal count.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 8'd14, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Load beats count in the same cycle, then a normal count.
    step(1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Set beats clear on the same edge; clear alone then drops the flag.
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);

    // Back-to-back wraps with alternating direction.
    step(1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

    // Flags set and a mid-range value, then reset mid-cycle.
    step(1'b0, 1'b0, 1'b1, 8'd6, 1'b0);
    do_reset();

    // Randomised traffic.
    repeat (400) begin
      r = $urandom_range(0, 99);
      step(r < 85, 1'($urandom_range(0, 1)), r >= 93, 8'($urandom_range(0, 255)),
           $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    @(posedge Clk);
    #3;
    check("drain", 0, 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
